// File: rtl/ram_scheduler_pkg.sv
`default_nettype none
//============================================================================
// Module : ram_scheduler_pkg
// Brief  : Shared types and round-robin search helper for ram_scheduler.
// Rev    : 1.0
//============================================================================
package ram_scheduler_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned c_max_req = 8;

    // Index of the first set bit at or above ptr, wrapping at n; 0 when none set.
    function automatic int unsigned first_set_from(
        input logic [c_max_req-1:0] req,
        input int unsigned          ptr,
        input int unsigned          n
    );
        int unsigned idx;
        int unsigned k;
        logic        found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < c_max_req; i++) begin
            k = (ptr + i) % n;
            if ((i < n) && !found && req[k[2:0]]) begin
                idx   = k;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_scheduler_rr_arbiter.sv
`default_nettype none
//============================================================================
// Module : rr_arbiter
// Brief  : Round-robin arbiter; pointer moves past the winner on advance.
// Rev    : 1.0
//============================================================================
module rr_arbiter
    import ram_scheduler_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0]     r_ptr;
    logic [c_max_req-1:0] w_req_pad;
    logic                 w_any;

    assign w_req_pad = c_max_req'(req);
    assign w_any     = |req;
    assign gnt_idx   = IDX_W'(first_set_from(w_req_pad, 32'(r_ptr), NUM_REQ));

    always_comb begin
        gnt = '0;
        if (w_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (advance && w_any) begin
            r_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_scheduler.sv
`default_nettype none
//============================================================================
// Module : ram_scheduler
// Brief  : Zero-fills a shared RAM, then grants one access per cycle round-robin.
// Rev    : 1.0
//============================================================================
module ram_scheduler
    import ram_scheduler_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int RAM_SIZE   = 64,
    parameter  int NUM_REQ    = 2,
    localparam int ADDR_WIDTH = $clog2(RAM_SIZE),
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    output logic                          init_done,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [ADDR_WIDTH-1:0]         ram_r_addr,
    output logic [ADDR_WIDTH-1:0]         ram_w_addr,
    output logic                          ram_w_enable,
    output logic [DATA_WIDTH-1:0]         ram_data_in,
    input  logic [DATA_WIDTH-1:0]         ram_data_out
);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_fill_cnt;
    logic [NUM_REQ-1:0]    r_rd_valid;
    logic [NUM_REQ-1:0]    w_arb_gnt;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_run_access;
    logic                  w_fill_last;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    // Clear wins over any request, so the pointer only moves on a real grant.
    assign w_run_access = (r_state == RUN) && !clear && (|req);
    assign w_fill_last  = (r_fill_cnt == ADDR_WIDTH'(RAM_SIZE - 1));
    assign w_sel_we     = req_we[w_idx];
    assign w_sel_addr   = req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_wdata  = req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (w_run_access),
        .gnt     (w_arb_gnt),
        .gnt_idx (w_idx)
    );

    always_comb begin
        w_state_next = r_state;
        init_done    = 1'b0;
        gnt          = '0;
        ram_r_addr   = '0;
        ram_w_addr   = '0;
        ram_w_enable = 1'b0;
        ram_data_in  = '0;
        case (r_state)
            FILL: begin
                ram_w_enable = 1'b1;
                ram_w_addr   = r_fill_cnt;
                if (w_fill_last) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                init_done = 1'b1;
                if (clear) begin
                    w_state_next = FILL;
                end else if (|req) begin
                    gnt = w_arb_gnt;
                    if (w_sel_we) begin
                        ram_w_enable = 1'b1;
                        ram_w_addr   = w_sel_addr;
                        ram_data_in  = w_sel_wdata;
                    end else begin
                        ram_r_addr = w_sel_addr;
                    end
                end
            end
            default: w_state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FILL;
            r_fill_cnt <= '0;
            r_rd_valid <= '0;
        end else begin
            r_state    <= w_state_next;
            r_fill_cnt <= ((r_state == FILL) && !w_fill_last) ? r_fill_cnt + 1'b1 : '0;
            r_rd_valid <= (w_run_access && !w_sel_we) ? w_arb_gnt : '0;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = ram_data_out;

endmodule
`default_nettype wire

// File: tb/tb_ram_scheduler.sv
`default_nettype none
//============================================================================
// Module : tb_ram_scheduler
// Brief  : Vector table, corner sequences and randomized model check.
// Rev    : 1.0
//============================================================================
module tb_ram_scheduler;

    localparam int DW = 8;
    localparam int RS = 64;
    localparam int AW = 6;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]    req = '0;
    logic [NR-1:0]    req_we = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic             init_done;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    rd_valid;
    logic [DW-1:0]    rd_data;
    logic [AW-1:0]    ram_r_addr;
    logic [AW-1:0]    ram_w_addr;
    logic             ram_w_enable;
    logic [DW-1:0]    ram_data_in;
    logic [DW-1:0]    ram_data_out;

    ram_scheduler #(.DATA_WIDTH(DW), .RAM_SIZE(RS), .NUM_REQ(NR)) u_dut (
        .clk(clk), .reset(reset), .clear(clear), .init_done(init_done),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr), .ram_w_enable(ram_w_enable),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    // Simple dual-port RAM: registered read, read-before-write; backdoor preload.
    logic [DW-1:0] mem [RS];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;
    always @(posedge clk) begin
        ram_data_out <= mem[ram_r_addr];
        if (ram_w_enable) mem[ram_w_addr] <= ram_data_in;
        if (bd_we) mem[bd_addr] <= bd_data;
    end

    // Four-requester instance used only for the wrap-around grant check.
    logic [3:0]      req4 = '0;
    logic [3:0]      we4 = '0;
    logic [4*AW-1:0] addr4 = '0;
    logic [4*DW-1:0] wdata4 = '0;
    logic [DW-1:0]   dout4 = '0;
    logic            clear4 = 1'b0;
    logic [3:0]      gnt4;
    logic [3:0]      rv4;
    logic            init4;
    logic [DW-1:0]   rd4;
    logic [DW-1:0]   din4;
    logic [AW-1:0]   ra4;
    logic [AW-1:0]   wa4;
    logic            wen4;

    ram_scheduler #(.DATA_WIDTH(DW), .RAM_SIZE(RS), .NUM_REQ(4)) u_dut4 (
        .clk(clk), .reset(reset), .clear(clear4), .init_done(init4),
        .req(req4), .req_we(we4), .req_addr(addr4), .req_wdata(wdata4),
        .gnt(gnt4), .rd_valid(rv4), .rd_data(rd4),
        .ram_r_addr(ra4), .ram_w_addr(wa4), .ram_w_enable(wen4),
        .ram_data_in(din4), .ram_data_out(dout4)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] req;
        logic [1:0] we;
        logic [5:0] a0;
        logic [5:0] a1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] gnt;
        logic       wen;
        logic [1:0] rv;
        logic [7:0] rd;
    } vec_t;

    vec_t tbl [12];

    // Reference model state for the randomized phase.
    logic [DW-1:0] ref_mem [RS];
    int            fill_left;
    int            ptr;
    logic [NR-1:0] exp_rv;
    logic [DW-1:0] exp_rd;

    initial begin
        int nz;
        int g;

        tbl[0]  = '{2'b11, 2'b11, 6'd3, 6'd7, 8'h33, 8'h77, 2'b01, 1'b1, 2'b00, 8'h00};
        tbl[1]  = '{2'b11, 2'b10, 6'd3, 6'd7, 8'h00, 8'h77, 2'b10, 1'b1, 2'b00, 8'h00};
        tbl[2]  = '{2'b11, 2'b00, 6'd3, 6'd7, 8'h00, 8'h00, 2'b01, 1'b0, 2'b00, 8'h00};
        tbl[3]  = '{2'b11, 2'b00, 6'd3, 6'd7, 8'h00, 8'h00, 2'b10, 1'b0, 2'b01, 8'h33};
        tbl[4]  = '{2'b11, 2'b00, 6'd3, 6'd7, 8'h00, 8'h00, 2'b01, 1'b0, 2'b10, 8'h77};
        tbl[5]  = '{2'b11, 2'b00, 6'd3, 6'd7, 8'h00, 8'h00, 2'b10, 1'b0, 2'b01, 8'h33};
        tbl[6]  = '{2'b01, 2'b01, 6'd5, 6'd0, 8'hA5, 8'h00, 2'b01, 1'b1, 2'b10, 8'h77};
        tbl[7]  = '{2'b01, 2'b00, 6'd5, 6'd0, 8'h00, 8'h00, 2'b01, 1'b0, 2'b00, 8'h00};
        tbl[8]  = '{2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00, 2'b00, 1'b0, 2'b01, 8'hA5};
        tbl[9]  = '{2'b10, 2'b10, 6'd0, 6'd9, 8'h00, 8'hC3, 2'b10, 1'b1, 2'b00, 8'h00};
        tbl[10] = '{2'b10, 2'b00, 6'd0, 6'd9, 8'h00, 8'h00, 2'b10, 1'b0, 2'b00, 8'h00};
        tbl[11] = '{2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00, 2'b00, 1'b0, 2'b10, 8'hC3};

        // Preload garbage while held in reset so the fill is observable.
        for (int i = 0; i < RS; i++) begin
            bd_we   = 1'b1;
            bd_addr = AW'(i);
            bd_data = DW'(i * 3 + 1);
            tick();
        end
        bd_we = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < RS; i++) begin
            @(negedge clk);
            chk("fill_init_done", 32'(init_done), 32'd0);
            chk("fill_wen", 32'(ram_w_enable), 32'd1);
            chk("fill_waddr", 32'(ram_w_addr), 32'(i));
            chk("fill_wdata", 32'(ram_data_in), 32'd0);
            chk("fill_gnt", 32'(gnt), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("run_init_done", 32'(init_done), 32'd1);
        chk("run_rd_valid", 32'(rd_valid), 32'd0);
        nz = 0;
        for (int i = 0; i < RS; i++) if (mem[i] != '0) nz++;
        chk("fill_all_zero", 32'(nz), 32'd0);
        tick();

        for (int r = 0; r < 12; r++) begin
            req       = tbl[r].req;
            req_we    = tbl[r].we;
            req_addr  = {tbl[r].a1, tbl[r].a0};
            req_wdata = {tbl[r].d1, tbl[r].d0};
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", r), 32'(gnt), 32'(tbl[r].gnt));
            chk($sformatf("vec%0d_wen", r), 32'(ram_w_enable), 32'(tbl[r].wen));
            chk($sformatf("vec%0d_rv", r), 32'(rd_valid), 32'(tbl[r].rv));
            if (tbl[r].rv != 2'b00)
                chk($sformatf("vec%0d_rd", r), 32'(rd_data), 32'(tbl[r].rd));
            tick();
        end

        // Wrap-around on the 4-requester instance: last grant index 3.
        req4 = 4'b1000;
        @(negedge clk);
        chk("rr4_g3", 32'(gnt4), 32'h8);
        tick();
        req4 = 4'b1001;
        @(negedge clk);
        chk("rr4_wrap0", 32'(gnt4), 32'h1);
        tick();
        @(negedge clk);
        chk("rr4_then3", 32'(gnt4), 32'h8);
        tick();
        req4 = 4'b0000;

        // Read just before clear, then clear with req0 pending.
        req = 2'b10; req_we = 2'b00; req_addr = {6'd7, 6'd5};
        @(negedge clk);
        chk("pre_clear_gnt", 32'(gnt), 32'h2);
        tick();
        req = 2'b01; clear = 1'b1;
        @(negedge clk);
        chk("clear_gnt", 32'(gnt), 32'd0);
        chk("clear_wen", 32'(ram_w_enable), 32'd0);
        chk("clear_init_done", 32'(init_done), 32'd1);
        chk("clear_rv", 32'(rd_valid), 32'h2);
        chk("clear_rd", 32'(rd_data), 32'h77);
        tick();
        for (int i = 0; i < RS; i++) begin
            clear = (i == 30 || i == 63);
            @(negedge clk);
            chk("cfill_init_done", 32'(init_done), 32'd0);
            chk("cfill_gnt", 32'(gnt), 32'd0);
            chk("cfill_waddr", 32'(ram_w_addr), 32'(i));
            if (i == 0) chk("cfill_rv0", 32'(rd_valid), 32'd0);
            tick();
        end
        clear = 1'b0;
        @(negedge clk);
        chk("crun_init_done", 32'(init_done), 32'd1);
        chk("crun_gnt", 32'(gnt), 32'h1);
        tick();
        req = 2'b00;
        @(negedge clk);
        chk("crun_rv", 32'(rd_valid), 32'h1);
        chk("crun_rd_zero", 32'(rd_data), 32'h00);
        tick();

        // Reset at fill counter 20; pointer (now 1) must return to 0.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rst20_waddr", 32'(ram_w_addr), 32'd20);
        tick();
        reset = 1'b0;
        req = 2'b11; req_we = 2'b00; req_addr = {6'd7, 6'd3};
        for (int i = 0; i < RS; i++) begin
            @(negedge clk);
            chk("rfill_waddr", 32'(ram_w_addr), 32'(i));
            chk("rfill_init_done", 32'(init_done), 32'd0);
            chk("rfill_rv", 32'(rd_valid), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("rrun_init_done", 32'(init_done), 32'd1);
        chk("rrun_gnt", 32'(gnt), 32'h1);
        tick();
        req = 2'b10;
        @(negedge clk);
        chk("rrun_gnt2", 32'(gnt), 32'h2);
        chk("rrun_rv", 32'(rd_valid), 32'h1);
        tick();
        req = 2'b00;
        @(negedge clk);
        chk("rrun_rv2", 32'(rd_valid), 32'h2);
        tick();

        // Randomized phase from a fresh reset against the reference model.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fill_left = RS;
        ptr = 0;
        exp_rv = '0;
        exp_rd = '0;
        for (int i = 0; i < RS; i++) ref_mem[i] = '0;
        g = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (g >= 0) req[g] = 1'b0;
            for (int k = 0; k < NR; k++) begin
                if (!req[k] && $urandom_range(0, 99) < 60) begin
                    req[k] = 1'b1;
                    req_we[k] = 1'($urandom_range(0, 1));
                    req_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
                    req_wdata[k*DW +: DW] = DW'($urandom_range(0, 255));
                end
            end
            clear = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            g = -1;
            chk("rnd_init_done", 32'(init_done), 32'(fill_left == 0));
            chk("rnd_rv", 32'(rd_valid), 32'(exp_rv));
            if (exp_rv != '0) chk("rnd_rd", 32'(rd_data), 32'(exp_rd));
            if (fill_left > 0) begin
                chk("rnd_fill_gnt", 32'(gnt), 32'd0);
                chk("rnd_fill_waddr", 32'(ram_w_addr), 32'(RS - fill_left));
            end else if (clear) begin
                chk("rnd_clear_gnt", 32'(gnt), 32'd0);
            end else begin
                for (int i = 0; i < NR; i++)
                    if (g < 0 && req[(ptr + i) % NR]) g = (ptr + i) % NR;
                chk("rnd_gnt", 32'(gnt), (g >= 0) ? 32'(1 << g) : 32'd0);
            end
            exp_rv = '0;
            if (fill_left > 0) begin
                fill_left--;
            end else if (clear) begin
                fill_left = RS;
                for (int i = 0; i < RS; i++) ref_mem[i] = '0;
            end else if (g >= 0) begin
                ptr = (g + 1) % NR;
                if (req_we[g]) begin
                    ref_mem[req_addr[g*AW +: AW]] = req_wdata[g*DW +: DW];
                end else begin
                    exp_rv = NR'(1 << g);
                    exp_rd = ref_mem[req_addr[g*AW +: AW]];
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
